// File: rtl/qlearning_episode_controller.sv
// Episode sequencer for a Q-learning accelerator on a 6x6 grid world.
// Tracks the agent cell, picks an epsilon-greedy action from the Q row,
// computes next cell and Q8.8 reward, and strobes one update per step.
module qlearning_episode_controller #(
  parameter logic [5:0]  START_STATE = 6'd0,
  parameter logic [5:0]  GOAL_STATE  = 6'd25,
  parameter logic [63:0] HAZARD_MASK = 64'h0000_0000_0048_6098,
  parameter int          MAX_STEPS   = 15,
  parameter int          EPSILON     = 26,
  parameter int          Q_LAT       = 2,
  parameter int          UPD_LAT     = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_episodes,
  input  logic [63:0] Q_out_action,
  output logic        acc_en,
  output logic [5:0]  acc_current_state,
  output logic [5:0]  acc_next_state,
  output logic [3:0]  acc_current_action,
  output logic [15:0] acc_current_reward,
  output logic        busy,
  output logic        done,
  output logic [15:0] episode_count,
  output logic [7:0]  step_count
);

  localparam logic [15:0] REWARD_GOAL    = 16'h6400;
  localparam logic [15:0] REWARD_TIMEOUT = 16'hCE00;
  localparam logic [15:0] REWARD_HAZARD  = 16'h9C00;
  localparam logic [15:0] REWARD_NONE    = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_SELECT = 3'd2,
    S_UPDATE = 3'd3,
    S_WAIT   = 3'd4,
    S_EPEND  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             state_r;
  logic [7:0]         wait_cnt_r;
  logic [15:0]        lfsr_r;
  logic [15:0]        num_episodes_r;
  logic               terminal_r;

  logic signed [15:0] q_s [4];
  logic [1:0]         best_idx_s;
  logic signed [15:0] best_val_s;
  logic               explore_s;
  logic [1:0]         action_s;
  logic [5:0]         col_s;
  logic [5:0]         next_state_s;
  logic [7:0]         step_next_s;
  logic [15:0]        reward_s;
  logic               terminal_s;

  // Slice the Q row and find the signed argmax, lowest index winning ties.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      q_s[i] = Q_out_action[16*i +: 16];
    end
    best_idx_s = 2'd0;
    best_val_s = q_s[0];
    for (int i = 1; i < 4; i++) begin
      if (q_s[i] > best_val_s) begin
        best_idx_s = 2'(i);
        best_val_s = q_s[i];
      end else begin
        best_idx_s = best_idx_s;
        best_val_s = best_val_s;
      end
    end
  end

  // Epsilon-greedy choice, grid move with wall clamping, reward and terminal flag.
  always_comb begin
    explore_s = ({24'd0, lfsr_r[7:0]} < EPSILON[31:0]);
    if (explore_s) begin
      action_s = lfsr_r[9:8];
    end else begin
      action_s = best_idx_s;
    end

    col_s = acc_current_state % 6'd6;
    case (action_s)
      2'd0:    next_state_s = (acc_current_state >= 6'd6)  ? acc_current_state - 6'd6 : acc_current_state;
      2'd1:    next_state_s = (acc_current_state <  6'd30) ? acc_current_state + 6'd6 : acc_current_state;
      2'd2:    next_state_s = (col_s != 6'd0) ? acc_current_state - 6'd1 : acc_current_state;
      2'd3:    next_state_s = (col_s != 6'd5) ? acc_current_state + 6'd1 : acc_current_state;
      default: next_state_s = acc_current_state;
    endcase

    step_next_s = step_count + 8'd1;
    if (next_state_s == GOAL_STATE) begin
      reward_s = REWARD_GOAL;
    end else if (step_next_s == MAX_STEPS[7:0]) begin
      reward_s = REWARD_TIMEOUT;
    end else if (HAZARD_MASK[next_state_s]) begin
      reward_s = REWARD_HAZARD;
    end else begin
      reward_s = REWARD_NONE;
    end
    terminal_s = (next_state_s == GOAL_STATE) || (step_next_s == MAX_STEPS[7:0]) ||
                 HAZARD_MASK[next_state_s];
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Episode state machine with registered accelerator and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r            <= S_IDLE;
      wait_cnt_r         <= 8'd0;
      num_episodes_r     <= 16'd0;
      terminal_r         <= 1'b0;
      acc_en             <= 1'b0;
      acc_current_state  <= START_STATE;
      acc_next_state     <= 6'd0;
      acc_current_action <= 4'd0;
      acc_current_reward <= 16'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      episode_count      <= 16'd0;
      step_count         <= 8'd0;
    end else begin
      acc_en <= 1'b0;
      case (state_r)
        // DONE behaves like IDLE once a new start arrives.
        S_IDLE, S_DONE: begin
          if (start) begin
            num_episodes_r <= num_episodes;
            episode_count  <= 16'd0;
            if (num_episodes == 16'd0) begin
              state_r <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r           <= S_READ;
              done              <= 1'b0;
              busy              <= 1'b1;
              acc_current_state <= START_STATE;
              step_count        <= 8'd0;
              wait_cnt_r        <= 8'd0;
            end
          end else begin
            state_r <= state_r;
          end
        end
        S_READ: begin
          if (wait_cnt_r == Q_LAT[7:0] - 8'd1) begin
            state_r    <= S_SELECT;
            wait_cnt_r <= 8'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_SELECT: begin
          acc_current_action <= {2'b00, action_s};
          acc_next_state     <= next_state_s;
          acc_current_reward <= reward_s;
          terminal_r         <= terminal_s;
          step_count         <= step_next_s;
          acc_en             <= 1'b1;
          state_r            <= S_UPDATE;
        end
        S_UPDATE: begin
          state_r    <= S_WAIT;
          wait_cnt_r <= 8'd0;
        end
        S_WAIT: begin
          if (wait_cnt_r == UPD_LAT[7:0] - 8'd1) begin
            wait_cnt_r <= 8'd0;
            if (terminal_r) begin
              state_r <= S_EPEND;
            end else begin
              acc_current_state <= acc_next_state;
              state_r           <= S_READ;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        S_EPEND: begin
          episode_count <= episode_count + 16'd1;
          if (episode_count + 16'd1 == num_episodes_r) begin
            state_r <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            acc_current_state <= START_STATE;
            step_count        <= 8'd0;
            wait_cnt_r        <= 8'd0;
            state_r           <= S_READ;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
